instruction_fetch_unit: RTL

- Producer side of the 16-bit Instruction interface consumed by the decode controller.
- Owns the fetch PC and issues one-at-a-time requests to instruction memory.
- Buffers returned words in a small FIFO and presents them, with their PC, to decode under a valid/ready handshake.
- Applies jump and branch redirects from the controller, flushing stale fetches.

---
 rtl/instruction_fetch_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch PC owner: one-at-a-time instruction memory requests, small instruction FIFO to decode, jump/branch redirects.
// Optional FETCH_PERF_COUNT_EN adds FlushCount and StallCycles saturating counters.
module instruction_fetch_unit #(
    parameter int ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH = 2,
    parameter int RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ImemReqValid,
    input  logic                  ImemReqReady,
    output logic [ADDR_WIDTH-1:0] ImemReqAddr,
    input  logic                  ImemRespValid,
    input  logic [15:0]           ImemRespData,
    output logic [15:0]           Instruction,
    output logic [ADDR_WIDTH-1:0] InstructionPc,
    output logic                  InstructionValid,
    input  logic                  InstructionReady,
    input  logic                  LoadPcEnable,
    input  logic                  SelectJumpPc,
    input  logic                  SelectBranchPc,
    input  logic                  ZeroFlag,
    input  logic [ADDR_WIDTH-1:0] JumpTarget,
    input  logic [7:0]            BranchOffset
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [15:0]           FlushCount,
    output logic [15:0]           StallCycles
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   fetch_pc;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic                    req_valid;
    logic [15:0]             fifo_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        wr_ptr;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        count_after;
    logic                    redirect;
    logic [ADDR_WIDTH-1:0]   target;
    logic                    push;
    logic                    pop;

    assign ImemReqValid     = req_valid;
    assign ImemReqAddr      = req_addr;
    assign InstructionValid = (count != '0);
    assign Instruction      = InstructionValid ? fifo_data[rd_ptr] : 16'h0000;
    assign InstructionPc    = InstructionValid ? fifo_pc[rd_ptr] : '0;

    // Branch target is relative to the instruction currently at the decode head.
    assign redirect = LoadPcEnable && (SelectJumpPc || (SelectBranchPc && ZeroFlag));
    assign target   = SelectJumpPc ? JumpTarget
                    : InstructionPc + ADDR_WIDTH'(1) + ADDR_WIDTH'($signed(BranchOffset));

    assign push        = (state == WAIT) && ImemRespValid && !redirect;
    assign pop         = InstructionValid && InstructionReady;
    assign count_after = count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= ImemRespData;
            fifo_pc[wr_ptr]   <= req_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            fetch_pc  <= ADDR_WIDTH'(RESET_PC);
            req_addr  <= ADDR_WIDTH'(RESET_PC);
            req_valid <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count_after;
            end

            case (state)
                IDLE: begin
                    if (redirect) begin
                        fetch_pc <= target;
                    end else if (count < CNT_W'(FIFO_DEPTH)) begin
                        state     <= REQ;
                        req_valid <= 1'b1;
                        req_addr  <= fetch_pc;
                    end
                end
                REQ: begin
                    if (ImemReqReady) begin
                        req_valid <= 1'b0;
                        fetch_pc  <= redirect ? target : fetch_pc + ADDR_WIDTH'(1);
                        state     <= redirect ? DROP : WAIT;
                    end else if (redirect) begin
                        req_valid <= 1'b0;
                        fetch_pc  <= target;
                        state     <= IDLE;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        fetch_pc <= target;
                        state    <= ImemRespValid ? IDLE : DROP;
                    end else if (ImemRespValid) begin
                        if (count_after < CNT_W'(FIFO_DEPTH)) begin
                            state     <= REQ;
                            req_valid <= 1'b1;
                            req_addr  <= fetch_pc;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (redirect)      fetch_pc <= target;
                    if (ImemRespValid) state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_COUNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'h0001;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            FlushCount  <= 16'h0000;
            StallCycles <= 16'h0000;
        end else begin
            if (redirect)                     FlushCount  <= sat_inc(FlushCount);
            if (req_valid && !ImemReqReady)   StallCycles <= sat_inc(StallCycles);
        end
    end
`endif

endmodule
